// File: rtl/map_writer.sv
// map_writer: write-side engine for the tilemap RAM.
// Takes single-byte writes or fills from the CPU over valid/ready.
// Issues one RAM write per granted cycle. The video side may withhold
// the port at any time by dropping mem_grant_i.
module map_writer #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_fill_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [ADDR_W:0]   req_count_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic              mem_grant_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              busy_o,
  output logic              done_o
);

  // Remaining-count width: one bit wider than the address so that a
  // full-depth fill (and beyond) can be expressed.
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   data_nxt;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_nxt;
  logic                done_q;
  logic                done_nxt;
  logic                active;

  // Engine owns the RAM port whenever a request is in flight.
  assign active = (state != IDLE);

  // Handshake and RAM-side outputs decoded from registered state.
  // The strobe is gated by the state register, so an async reset
  // removes it without waiting for a clock edge.
  assign req_ready_o = !active;
  assign busy_o      = active;
  assign mem_we_o    = active && mem_grant_i;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;
  assign done_o      = done_q;

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      data_q  <= data_nxt;
      count_q <= count_nxt;
      done_q  <= done_nxt;
    end
  end

  // Next-state logic: accept in IDLE, advance one byte per granted cycle.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    count_nxt = count_q;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid_i) begin
          addr_nxt = req_addr_i;
          data_nxt = req_data_i;
          if (!req_fill_i) begin
            count_nxt = CNT_W'(1);
            state_nxt = WRITE;
          end else if (req_count_i != '0) begin
            count_nxt = req_count_i;
            state_nxt = FILL;
          end else begin
            // Zero-length fill completes at once without touching the RAM.
            count_nxt = '0;
            done_nxt  = 1'b1;
          end
        end
      end

      WRITE, FILL: begin
        // Withheld grant is a stall: everything holds.
        if (mem_grant_i) begin
          addr_nxt  = addr_q + ADDR_W'(1);
          count_nxt = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_map_writer.sv
// Self-checking bench for map_writer: scoreboard of expected RAM writes
// plus per-scenario cycle checks on the handshake and done pulse.
module tb_map_writer;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 8;

  logic              clk;
  logic              rst_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_fill_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [ADDR_W:0]   req_count_i;
  logic [DATA_W-1:0] req_data_i;
  logic              mem_grant_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              busy_o;
  logic              done_o;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  map_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_fill_i  (req_fill_i),
    .req_addr_i  (req_addr_i),
    .req_count_i (req_count_i),
    .req_data_i  (req_data_i),
    .mem_grant_i (mem_grant_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: each strobe seen mid-cycle fires at the next posedge.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (done_o) done_cnt++;
      if (!mem_grant_i) begin
        total++;
        if (mem_we_o !== 1'b0) begin
          bad++;
          $display("FAIL strobe_without_grant we=%b grant=0", mem_we_o);
        end
      end
      if (mem_we_o) begin
        logic [ADDR_W+DATA_W-1:0] e;
        wr_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write addr=%h data=%h", mem_addr_o, mem_data_o);
        end else begin
          e = exp_q.pop_front();
          if ({mem_addr_o, mem_data_o} !== e) begin
            bad++;
            $display("FAIL write_content got addr=%h data=%h want addr=%h data=%h",
                     mem_addr_o, mem_data_o, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    total++;
    if ({req_ready_o, busy_o, done_o, mem_we_o} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_ctrl got rdy/busy/done/we=%b want 1000",
               {req_ready_o, busy_o, done_o, mem_we_o});
    end
    total++;
    if ({mem_addr_o, mem_data_o} !== '0) begin
      bad++;
      $display("FAIL reset_regs got addr=%h data=%h want 0", mem_addr_o, mem_data_o);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    int w0;
    w0 = wr_cnt;
    req_valid_i = 1'b1; req_fill_i = 1'b0; req_addr_i = 9'h005; req_data_i = 8'hA7;
    req_count_i = 10'd0;
    exp_q.push_back({9'h005, 8'hA7});
    tick();                       // accept edge
    req_valid_i = 1'b0;
    total++;
    if ({req_ready_o, busy_o, mem_we_o, done_o} !== 4'b0110) begin
      bad++;
      $display("FAIL single_active got rdy/busy/we/done=%b want 0110",
               {req_ready_o, busy_o, mem_we_o, done_o});
    end
    tick();                       // write fires
    total++;
    if ({req_ready_o, busy_o, mem_we_o, done_o} !== 4'b1001) begin
      bad++;
      $display("FAIL single_done got rdy/busy/we/done=%b want 1001",
               {req_ready_o, busy_o, mem_we_o, done_o});
    end
    tick();
    total++;
    if (done_o !== 1'b0) begin
      bad++;
      $display("FAIL single_done_width got done=%b want 0", done_o);
    end
    total++;
    if (wr_cnt - w0 != 1) begin
      bad++;
      $display("FAIL single_count got %0d writes want 1", wr_cnt - w0);
    end
  endtask

  task automatic test_fill_wrap();
    int busy_cyc;
    int w0;
    int d0;
    busy_cyc = 0;
    w0 = wr_cnt;
    d0 = done_cnt;
    req_valid_i = 1'b1; req_fill_i = 1'b1; req_addr_i = 9'h1FE; req_count_i = 10'd4;
    req_data_i = 8'h20;
    exp_q.push_back({9'h1FE, 8'h20});
    exp_q.push_back({9'h1FF, 8'h20});
    exp_q.push_back({9'h000, 8'h20});
    exp_q.push_back({9'h001, 8'h20});
    tick();
    req_valid_i = 1'b0;
    req_addr_i = 9'h0AA; req_data_i = 8'hEE; // must be ignored mid-request
    for (int i = 0; i < 8; i++) begin
      if (busy_o) busy_cyc++;
      tick();
    end
    total++;
    if (busy_cyc != 4) begin
      bad++;
      $display("FAIL fill_busy got %0d cycles want 4", busy_cyc);
    end
    total++;
    if (wr_cnt - w0 != 4 || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL fill_counts got writes=%0d dones=%0d want 4/1", wr_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_fill_stall();
    int done_at;
    int w0;
    done_at = -1;
    w0 = wr_cnt;
    req_valid_i = 1'b1; req_fill_i = 1'b1; req_addr_i = 9'h010; req_count_i = 10'd3;
    req_data_i = 8'h33;
    for (int i = 0; i < 3; i++) exp_q.push_back({9'(9'h010 + i), 8'h33});
    tick();                       // accept
    req_valid_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) mem_grant_i = 1'b0;
      if (k == 3) mem_grant_i = 1'b1;
      if (done_o && done_at < 0) done_at = k;
    end
    total++;
    if (done_at != 5) begin
      bad++;
      $display("FAIL stall_done_cycle got %0d want 5", done_at);
    end
    total++;
    if (wr_cnt - w0 != 3) begin
      bad++;
      $display("FAIL stall_count got %0d writes want 3", wr_cnt - w0);
    end
  endtask

  task automatic test_fill_zero();
    int w0;
    int d0;
    int rdy_low;
    w0 = wr_cnt;
    d0 = done_cnt;
    rdy_low = 0;
    req_valid_i = 1'b1; req_fill_i = 1'b1; req_addr_i = 9'h100; req_count_i = 10'd0;
    req_data_i = 8'h55;
    tick();
    req_valid_i = 1'b0;
    total++;
    if ({req_ready_o, busy_o, done_o} !== 3'b101) begin
      bad++;
      $display("FAIL zero_fill_done got rdy/busy/done=%b want 101", {req_ready_o, busy_o, done_o});
    end
    for (int i = 0; i < 4; i++) begin
      if (!req_ready_o) rdy_low++;
      tick();
    end
    total++;
    if (rdy_low != 0 || wr_cnt != w0 || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL zero_fill_counts got rdy_low=%0d writes=%0d dones=%0d want 0/0/1",
               rdy_low, wr_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_fill();
    int w0;
    int d0;
    w0 = wr_cnt;
    req_valid_i = 1'b1; req_fill_i = 1'b1; req_addr_i = 9'h080; req_count_i = 10'd100;
    req_data_i = 8'h9C;
    for (int i = 0; i < 10; i++) exp_q.push_back({9'(9'h080 + i), 8'h9C});
    tick();                       // accept
    req_valid_i = 1'b0;
    repeat (10) tick();           // ten writes fire
    total++;
    if (mem_we_o !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre_we got we=%b want 1", mem_we_o);
    end
    #2 rst_i = 1'b1;
    #1;
    total++;
    if (mem_we_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_async_we got we=%b want 0", mem_we_o);
    end
    repeat (2) tick();
    rst_i = 1'b0;
    d0 = done_cnt;
    tick();
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL abort_ready got %b want 1", req_ready_o);
    end
    repeat (5) tick();
    total++;
    if (wr_cnt - w0 != 10 || done_cnt != d0) begin
      bad++;
      $display("FAIL abort_counts got writes=%0d dones=%0d want 10/0", wr_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    req_valid_i = 1'b1; req_fill_i = 1'b0; req_addr_i = 9'h040; req_data_i = 8'h11;
    exp_q.push_back({9'h040, 8'h11});
    exp_q.push_back({9'h041, 8'h22});
    tick();                       // accept at T
    req_addr_i = 9'h041; req_data_i = 8'h22;
    total++;
    if ({mem_we_o, mem_addr_o} !== {1'b1, 9'h040}) begin
      bad++;
      $display("FAIL b2b_first got we=%b addr=%h want 1/040", mem_we_o, mem_addr_o);
    end
    tick();                       // T+1 write fires
    total++;
    if ({req_ready_o, done_o, mem_we_o} !== 3'b110) begin
      bad++;
      $display("FAIL b2b_gap got rdy/done/we=%b want 110", {req_ready_o, done_o, mem_we_o});
    end
    tick();                       // T+2 second accept
    req_valid_i = 1'b0;
    total++;
    if ({mem_we_o, mem_addr_o} !== {1'b1, 9'h041}) begin
      bad++;
      $display("FAIL b2b_second got we=%b addr=%h want 1/041", mem_we_o, mem_addr_o);
    end
    tick();                       // T+3 write fires
    total++;
    if ({req_ready_o, done_o} !== 2'b11) begin
      bad++;
      $display("FAIL b2b_done got rdy/done=%b want 11", {req_ready_o, done_o});
    end
    tick();
  endtask

  task automatic test_drained();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    req_fill_i = 1'b0;
    req_addr_i = '0;
    req_count_i = '0;
    req_data_i = '0;
    mem_grant_i = 1'b1;
    test_reset();
    test_single_write();
    test_fill_wrap();
    test_fill_stall();
    test_fill_zero();
    test_reset_mid_fill();
    test_back_to_back();
    test_drained();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
